hexkeypad_scan: RTL
===================

# hexkeypad_scan

Input-side companion to the seven-segment display driver: scans a 4x4 hex keypad by driving one row low at a time and sampling the column lines. It debounces key presses and shifts each new hex digit into a 16-bit value register. That register is wired straight to the display driver's `value` input, so typed digits appear on the four-digit display.

## Interface
Parameters:
- `DWELL_BITS`, 10: each row is driven for 2^DWELL_BITS clocks; must be >= 2.
- `DEBOUNCE`, 4: number of consecutive identical full scans needed to accept a press or a release; 1..15.

Ports:
- `clk`, in, 1: system clock, single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `row`, out, 4: row drive, active low; exactly one bit is low at all times.
- `col`, in, 4: column sense, active low (board pull-ups), asynchronous.
- `value`, out, 16: shifted digit register; the newest digit sits in `[3:0]`.
- `key_code`, out, 4: code of the last accepted key.
- `key_valid`, out, 1: one-clock pulse when a press is accepted.
- `key_down`, out, 1: high while a debounced key is held.

## Operation
- `col` passes through a 2-flop synchroniser before any use.
- Dwell counter, `DWELL_BITS` wide, counts freely. When it wraps, the active row advances 0→1→2→3→0. Row r is driven as `row = ~(4'b0001 << r)`.
- Columns are sampled on the last cycle of each dwell (counter all ones). This gives at least 2 cycles of settling after the row change, which covers synchroniser latency.
- Per-scan detector, accumulated over rows 0..3:
  - No column low in any row → scan result NONE.
  - Exactly one (row, col) low in the whole scan → result KEY with code = row*4 + col.
  - Two or more lows, in one row or across rows → result MULTI.
- Scan result is evaluated after row 3 is sampled. A debounce counter (4 bits) counts consecutive scans whose result equals the previous scan's result (same kind and same code). Any differing scan reloads the counter to 1.
- State machine, evaluated once per completed scan:
  - RELEASED: when DEBOUNCE consecutive KEY scans with the same code are seen → go to HELD. On that clock, `key_code` ← code, `value` ← `{value[11:0], code}`, `key_valid` = 1, `key_down` ← 1.
  - HELD: when DEBOUNCE consecutive NONE scans are seen → go to RELEASED and set `key_down` ← 0. KEY scans (same or different code) and MULTI scans keep HELD. There is no auto-repeat; a new digit requires a release first.
  - MULTI never causes a press; in RELEASED it only resets the debounce run.
- Reset values: `row`=4'b1110, `value`=0, `key_code`=0, `key_valid`=0, `key_down`=0, state=RELEASED, all counters 0, scan accumulator cleared.
- Reset asserted mid-scan or while HELD: everything returns to the reset values on the next clock, and no `key_valid` pulse is emitted. Scanning restarts at row 0 with a full dwell.

## Timing
- One scan lasts 4·2^DWELL_BITS clocks.
- Press latency: `key_valid` asserts on the clock after the final row-3 sample of the DEBOUNCE-th matching scan.
- `key_valid` is exactly 1 cycle wide. `value` and `key_code` update on the same edge, and the display sees the new `value` one clock later.
- Release is accepted on the clock after the final sample of the DEBOUNCE-th NONE scan.
- A `col` change lands in the synchroniser output 2 clocks later. Samples taken within 2 clocks of the change see the old level.
- The debounce counter saturates at DEBOUNCE and does not wrap.

## Structure
- Shared package holds:
  - the state enum (RELEASED, HELD);
  - scan result kinds (NONE, KEY, MULTI);
  - `ROW_IDLE` = 4'b1111.
- One natural sub-module, `keypad_sync2`: a 4-bit 2-flop synchroniser for `col`. Scanner, detector and FSM stay in the top module.

## Test plan
Bench settings: DWELL_BITS=2, DEBOUNCE=3, so one scan = 16 clocks.
- Reset check: after reset, `row`=4'b1110, `value`=0, `key_down`=0. `row` steps 1110→1101→1011→0111 every 4 clocks.
- Single press: hold key row1/col2 (col[2] low only while row[1] is low) for 5 scans → exactly one `key_valid`, `key_code`=6, `value`=16'h0006, `key_down`=1.
- Digit sequence: press and release keys 1, 2, 10, 15 in turn → `value`=16'h12AF, with 4 `key_valid` pulses total.
- Bounce: toggle key 5 on and off every scan for 6 scans, then release → no `key_valid`, `value` unchanged.
- Multiple keys: hold keys 3 and 12 together for 6 scans → no press accepted. Then release key 12 → press accepted with code 3 after 3 more scans.
- Reset while held: hold key 9 until `key_down`=1, then assert `reset` for 1 clock → `value`=0, `key_down`=0, no pulse. With key 9 still held, a fresh press is accepted 3 scans later.

Source files
------------

// File: rtl/hexkeypad_scan_pkg.sv
// -----------------------------------------------------------------------------
// hexkeypad_scan_pkg
//
// Shared types and helpers for the 4x4 hex keypad scanner.
//   state_t        : debounced key state (RELEASED / HELD)
//   scan_kind_t    : classification of one complete four-row scan
//   scan_result_t  : scan kind plus the key code (code is 0 unless kind is KEY)
//   ROW_IDLE       : row / column level with nothing driven or pressed
//   count_lows()   : number of active-low lines in a 4-bit group
//   first_low()    : index of the lowest-numbered active-low line
// -----------------------------------------------------------------------------
package hexkeypad_scan_pkg;

   typedef enum logic {
      ST_RELEASED = 1'b0,
      ST_HELD     = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SCAN_NONE  = 2'd0,
      SCAN_KEY   = 2'd1,
      SCAN_MULTI = 2'd2
   } scan_kind_t;

   typedef struct packed {
      scan_kind_t kind;
      logic [3:0] code;
   } scan_result_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   localparam scan_result_t SCAN_RESULT_NONE = '{kind: SCAN_NONE, code: 4'd0};

   function automatic logic [2:0] count_lows(input logic [3:0] lines);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!lines[i]) n = n + 3'd1;
      end
      return n;
   endfunction

   // Walks downward so the last hit is the lowest index; only meaningful
   // when exactly one line is low, which is the only case that uses it.
   function automatic logic [1:0] first_low(input logic [3:0] lines);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!lines[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hexkeypad_scan_sync2.sv
// -----------------------------------------------------------------------------
// keypad_sync2
//
// Two-flop synchroniser for the asynchronous keypad column lines.
//   clk   : system clock
//   reset : synchronous, active-high; flops return to the idle (all-high) level
//   d     : raw column lines from the keypad (active low, pulled up)
//   q     : column lines synchronised to clk, two clocks behind d
// -----------------------------------------------------------------------------
module keypad_sync2
   import hexkeypad_scan_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge value of its source; with blocking assignments
   // meta and q would collapse into a single stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= ROW_IDLE;
         q    <= ROW_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hexkeypad_scan.sv
// -----------------------------------------------------------------------------
// hexkeypad_scan
//
// Scans a 4x4 hex keypad one row at a time, debounces whole-keypad scans and
// shifts each newly pressed hex digit into a 16-bit value register that feeds
// the seven-segment display driver.
//
// Parameters
//   DWELL_BITS : each row is driven for 2**DWELL_BITS clocks (>= 2)
//   DEBOUNCE   : consecutive identical scans to accept a press/release (1..15)
//
// Ports
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   row       : row drive, active low, exactly one bit low
//   col       : column sense, active low, asynchronous
//   value     : shifted digit register, newest digit in [3:0]
//   key_code  : code of the last accepted key
//   key_valid : one-clock pulse when a press is accepted
//   key_down  : high while a debounced key is held
// -----------------------------------------------------------------------------
module hexkeypad_scan
   import hexkeypad_scan_pkg::*;
#(
   parameter int DWELL_BITS = 10,
   parameter int DEBOUNCE   = 4
)(
   input  logic        clk,
   input  logic        reset,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   output logic [15:0] value,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down
);

   localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

   // ---------------------------------------------------------------------------
   // Column synchroniser
   // ---------------------------------------------------------------------------
   logic [3:0] col_sync;

   keypad_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (col),
      .q     (col_sync)
   );

   // ---------------------------------------------------------------------------
   // Row scanner: free-running dwell counter, row advances on wrap
   // ---------------------------------------------------------------------------
   logic [DWELL_BITS-1:0] dwell;
   logic [1:0]            row_idx;
   logic                  sample;     // last cycle of the dwell: columns settled
   logic                  scan_done;  // row 3 sampled this cycle

   assign sample    = &dwell;
   assign scan_done = sample && (row_idx == 2'd3);
   assign row       = ROW_IDLE ^ (4'b0001 << row_idx);

   // ---------------------------------------------------------------------------
   // Per-scan detector
   // acc_lows saturates at 2: beyond "more than one" the count is irrelevant.
   // ---------------------------------------------------------------------------
   logic [1:0]   acc_lows;
   logic [3:0]   acc_code;
   logic [2:0]   row_lows;
   logic [1:0]   merged_lows;
   logic [3:0]   merged_code;
   scan_result_t scan;

   // NOTE: every signal driven here gets a default before any condition, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      row_lows    = count_lows(col_sync);
      merged_lows = acc_lows;
      merged_code = acc_code;
      if (row_lows != 3'd0) begin
         if ((acc_lows == 2'd0) && (row_lows == 3'd1)) begin
            merged_lows = 2'd1;
            merged_code = {row_idx, first_low(col_sync)};
         end else begin
            merged_lows = 2'd2;
         end
      end
   end

   always_comb begin
      scan = SCAN_RESULT_NONE;
      case (merged_lows)
         2'd0:    scan = SCAN_RESULT_NONE;
         2'd1:    scan = '{kind: SCAN_KEY, code: merged_code};
         default: scan = '{kind: SCAN_MULTI, code: 4'd0};
      endcase
   end

   // ---------------------------------------------------------------------------
   // Debounce run counter: length of the current run of identical scans,
   // saturating at DEBOUNCE.
   // ---------------------------------------------------------------------------
   scan_result_t prev_scan;
   logic [3:0]   run;
   logic [3:0]   run_next;

   always_comb begin
      if (scan == prev_scan) begin
         run_next = (run >= DEB_MAX) ? DEB_MAX : run + 4'd1;
      end else begin
         run_next = 4'd1;
      end
   end

   // NOTE: reset is sampled synchronously here; every flop in the block,
   // including the scan accumulator, is returned to a known value so a reset
   // mid-scan cannot leak a partial scan into the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         dwell     <= '0;
         row_idx   <= 2'd0;
         acc_lows  <= 2'd0;
         acc_code  <= 4'd0;
         prev_scan <= SCAN_RESULT_NONE;
         run       <= 4'd0;
      end else begin
         dwell <= dwell + 1'b1;
         if (sample) begin
            row_idx <= row_idx + 2'd1;
            if (scan_done) begin
               acc_lows  <= 2'd0;
               acc_code  <= 4'd0;
               prev_scan <= scan;
               run       <= run_next;
            end else begin
               acc_lows <= merged_lows;
               acc_code <= merged_code;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Key state machine, evaluated once per completed scan
   // ---------------------------------------------------------------------------
   state_t state;
   state_t next_state;
   logic   press;
   logic   release_key;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RELEASED;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (scan_done) begin
         case (state)
            ST_RELEASED: begin
               // MULTI and NONE only restart the run; no auto-repeat from HELD.
               if ((scan.kind == SCAN_KEY) && (run_next == DEB_MAX)) next_state = ST_HELD;
            end
            ST_HELD: begin
               if ((scan.kind == SCAN_NONE) && (run_next == DEB_MAX)) next_state = ST_RELEASED;
            end
            default: next_state = ST_RELEASED;
         endcase
      end
   end

   always_comb begin
      press       = (state == ST_RELEASED) && (next_state == ST_HELD);
      release_key = (state == ST_HELD) && (next_state == ST_RELEASED);
   end

   // Registered outputs; key_code and value update on the same edge as the
   // key_valid pulse is raised. press still carries this scan's code.
   always_ff @(posedge clk) begin
      if (reset) begin
         value     <= 16'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         key_valid <= press;
         if (press) begin
            value    <= {value[11:0], scan.code};
            key_code <= scan.code;
            key_down <= 1'b1;
         end else if (release_key) begin
            key_down <= 1'b0;
         end
      end
   end

endmodule
